// File: rtl/trap_pkg.sv
// Shared constants for the M-mode trap sequencer: FSM state codes, CSR addresses,
// mstatus/mie bit positions, cause codes and mtval selection helpers.
package trap_pkg;

    localparam logic [1:0] XLEN_64B = 2'd2;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_W_EPC   = 3'd1;
    localparam logic [2:0] ST_W_CAUSE = 3'd2;
    localparam logic [2:0] ST_W_TVAL  = 3'd3;
    localparam logic [2:0] ST_W_STAT  = 3'd4;
    localparam logic [2:0] ST_M_STAT  = 3'd5;
    localparam logic [2:0] ST_REDIR   = 3'd6;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int unsigned MST_MIE    = 3;
    localparam int unsigned MST_MPIE   = 7;
    localparam int unsigned MST_MPP_LO = 11;
    localparam int unsigned MST_MPP_HI = 12;
    localparam int unsigned MIE_MTIE   = 7;
    localparam int unsigned MIE_MEIE   = 11;

    localparam logic [3:0] EXC_IADDR_MISALIGN = 4'd0;
    localparam logic [3:0] EXC_IACCESS        = 4'd1;
    localparam logic [3:0] EXC_BREAK          = 4'd3;
    localparam logic [3:0] EXC_LADDR_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_SACCESS        = 4'd7;
    localparam logic [3:0] IRQ_MTI            = 4'd7;
    localparam logic [3:0] IRQ_MEI            = 4'd11;

    // E/M load/store faults report the data address
    function automatic logic em_tval_is_addr(input logic [3:0] code);
        return (code >= EXC_LADDR_MISALIGN) && (code <= EXC_SACCESS);
    endfunction

    // F/D fetch faults and breakpoints report the faulting PC
    function automatic logic fd_tval_is_pc(input logic [3:0] code);
        return (code == EXC_IADDR_MISALIGN) || (code == EXC_IACCESS) || (code == EXC_BREAK);
    endfunction

endpackage

// File: rtl/trap_cause_arbiter.sv
// Combinational priority select of the winning trap/MRET request:
// E/M exception > MRET > F/D exception > interrupt (MEI beats MTI).
module trap_cause_arbiter
    import trap_pkg::*;
#(
    parameter int unsigned W = 64
)
(
    input  logic         exc_valid_fd_i,
    input  logic [3:0]   exc_code_fd_i,
    input  logic [W-1:0] exc_pc_fd_i,
    input  logic         exc_valid_em_i,
    input  logic [3:0]   exc_code_em_i,
    input  logic [W-1:0] exc_pc_em_i,
    input  logic [W-1:0] exc_addr_em_i,
    input  logic         mret_i,
    input  logic         mei_i,
    input  logic         mti_i,
    input  logic         irq_en_i,
    input  logic [W-1:0] irq_pc_i,
    output logic         req_o,
    output logic         mret_o,
    output logic         irq_o,
    output logic [3:0]   code_o,
    output logic [W-1:0] epc_o,
    output logic [W-1:0] tval_o
);

    always_comb begin
        req_o  = 1'b1;
        mret_o = 1'b0;
        irq_o  = 1'b0;
        code_o = 4'd0;
        epc_o  = '0;
        tval_o = '0;
        if (exc_valid_em_i) begin
            code_o = exc_code_em_i;
            epc_o  = exc_pc_em_i;
            if (em_tval_is_addr(exc_code_em_i)) tval_o = exc_addr_em_i;
        end else if (mret_i) begin
            mret_o = 1'b1;
        end else if (exc_valid_fd_i) begin
            code_o = exc_code_fd_i;
            epc_o  = exc_pc_fd_i;
            if (fd_tval_is_pc(exc_code_fd_i)) tval_o = exc_pc_fd_i;
        end else if ((mei_i | mti_i) & irq_en_i) begin
            irq_o  = 1'b1;
            code_o = mei_i ? IRQ_MEI : IRQ_MTI;
            epc_o  = irq_pc_i;
        end else begin
            req_o  = 1'b0;
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// M-mode trap entry / MRET sequencer: serial CSR updates through one write port, then PC redirect.
// Optional interrupt support is compiled in with `define TRAP_SEQ_IRQ_EN.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter logic [1:0]  XLEN       = XLEN_64B,
    parameter logic [1:0]  RESET_PRIV = PRIV_M,
    localparam int unsigned W         = 32'd1 << (32'(XLEN) + 32'd4)
)
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clk_en,
    input  logic         i_exc_valid_fd,
    input  logic [3:0]   i_exc_code_fd,
    input  logic [W-1:0] i_exc_pc_fd,
    input  logic         i_exc_valid_em,
    input  logic [3:0]   i_exc_code_em,
    input  logic [W-1:0] i_exc_pc_em,
    input  logic [W-1:0] i_exc_addr_em,
    input  logic         i_mret_e,
    input  logic [W-1:0] i_mepc,
    input  logic [W-1:0] i_mtvec,
    input  logic [W-1:0] i_mstatus,
`ifdef TRAP_SEQ_IRQ_EN
    input  logic         i_mtip,
    input  logic         i_meip,
    input  logic [W-1:0] i_irq_pc,
    input  logic [W-1:0] i_mie,
`endif
    output logic         o_csr_wr_en,
    output logic [11:0]  o_csr_wr_addr,
    output logic [W-1:0] o_csr_wr_data,
    output logic         o_flush_fd,
    output logic         o_flush_em,
    output logic         o_stall,
    output logic         o_redirect,
    output logic [W-1:0] o_redirect_pc,
    output logic [1:0]   o_priv,
    output logic         o_busy
);

    logic [2:0]   state_q, state_d;
    logic         mret_q, mret_d, irq_q, irq_d;
    logic [3:0]   cause_q, cause_d;
    logic [W-1:0] epc_q, epc_d, tval_q, tval_d, mst_q, mst_d;
    logic         wr_en_q, wr_en_d;
    logic [11:0]  wr_addr_q, wr_addr_d;
    logic [W-1:0] wr_data_q, wr_data_d;
    logic         redir_q, redir_d;
    logic [W-1:0] redir_pc_q, redir_pc_d;
    logic [1:0]   priv_q, priv_d;
    logic         busy_q, busy_d;

    logic         arb_req, arb_mret, arb_irq;
    logic [3:0]   arb_code;
    logic [W-1:0] arb_epc, arb_tval;
    logic         mei, mti, irq_en;
    logic [W-1:0] irq_pc;
    logic [W-1:0] trap_pc;
    logic         accept;

`ifdef TRAP_SEQ_IRQ_EN
    logic unused_mie;
    assign mei        = i_meip & i_mie[MIE_MEIE];
    assign mti        = i_mtip & i_mie[MIE_MTIE];
    assign irq_en     = i_mstatus[MST_MIE] | (priv_q != PRIV_M);
    assign irq_pc     = i_irq_pc;
    assign unused_mie = ^{i_mie[W-1:12], i_mie[10:8], i_mie[6:0]};
`else
    assign mei    = 1'b0;
    assign mti    = 1'b0;
    assign irq_en = 1'b0;
    assign irq_pc = '0;
`endif

    trap_cause_arbiter #(.W(W)) u_arb (
        .exc_valid_fd_i (i_exc_valid_fd),
        .exc_code_fd_i  (i_exc_code_fd),
        .exc_pc_fd_i    (i_exc_pc_fd),
        .exc_valid_em_i (i_exc_valid_em),
        .exc_code_em_i  (i_exc_code_em),
        .exc_pc_em_i    (i_exc_pc_em),
        .exc_addr_em_i  (i_exc_addr_em),
        .mret_i         (i_mret_e),
        .mei_i          (mei),
        .mti_i          (mti),
        .irq_en_i       (irq_en),
        .irq_pc_i       (irq_pc),
        .req_o          (arb_req),
        .mret_o         (arb_mret),
        .irq_o          (arb_irq),
        .code_o         (arb_code),
        .epc_o          (arb_epc),
        .tval_o         (arb_tval)
    );

    // Flushes are the only same-cycle outputs: they fire on the accept cycle itself
    assign accept     = (state_q == ST_IDLE) & arb_req & i_clk_en & ~i_rst;
    assign o_flush_fd = accept;
    assign o_flush_em = accept;

    always_comb begin
        trap_pc = i_mtvec & ~W'(3);
`ifdef TRAP_SEQ_IRQ_EN
        if (irq_q && (i_mtvec[1:0] == 2'b01)) trap_pc = trap_pc + (W'(cause_q) << 2);
`endif
    end

    always_comb begin
        state_d    = state_q;
        mret_d     = mret_q;
        irq_d      = irq_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        tval_d     = tval_q;
        mst_d      = mst_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = 12'd0;
        wr_data_d  = '0;
        redir_d    = 1'b0;
        redir_pc_d = '0;
        priv_d     = priv_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_req) begin
                    state_d = arb_mret ? ST_M_STAT : ST_W_EPC;
                    mret_d  = arb_mret;
                    irq_d   = arb_irq;
                    cause_d = arb_code;
                    epc_d   = arb_epc;
                    tval_d  = arb_tval;
                    mst_d   = i_mstatus;
                end
            end
            ST_W_EPC:   state_d = ST_W_CAUSE;
            ST_W_CAUSE: state_d = ST_W_TVAL;
            ST_W_TVAL:  state_d = ST_W_STAT;
            ST_W_STAT:  state_d = ST_REDIR;
            ST_M_STAT:  state_d = ST_REDIR;
            default:    state_d = ST_IDLE;
        endcase

        // Registered outputs are decoded from the state being entered
        case (state_d)
            ST_W_EPC: begin
                wr_en_d   = 1'b1;
                wr_addr_d = CSR_MEPC;
                wr_data_d = epc_d;
            end
            ST_W_CAUSE: begin
                wr_en_d          = 1'b1;
                wr_addr_d        = CSR_MCAUSE;
                wr_data_d        = W'(cause_d);
                wr_data_d[W-1]   = irq_d;
            end
            ST_W_TVAL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = CSR_MTVAL;
                wr_data_d = tval_d;
            end
            ST_W_STAT: begin
                wr_en_d                           = 1'b1;
                wr_addr_d                         = CSR_MSTATUS;
                wr_data_d                         = mst_d;
                wr_data_d[MST_MPIE]               = mst_d[MST_MIE];
                wr_data_d[MST_MIE]                = 1'b0;
                wr_data_d[MST_MPP_HI:MST_MPP_LO]  = priv_q;
            end
            ST_M_STAT: begin
                wr_en_d                           = 1'b1;
                wr_addr_d                         = CSR_MSTATUS;
                wr_data_d                         = mst_d;
                wr_data_d[MST_MIE]                = mst_d[MST_MPIE];
                wr_data_d[MST_MPIE]               = 1'b1;
                wr_data_d[MST_MPP_HI:MST_MPP_LO]  = PRIV_U;
            end
            ST_REDIR: begin
                redir_d    = 1'b1;
                redir_pc_d = mret_d ? i_mepc : trap_pc;
                priv_d     = mret_d ? mst_d[MST_MPP_HI:MST_MPP_LO] : PRIV_M;
            end
            default: ;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // All state, including registered outputs, freezes while i_clk_en is low
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            mret_q     <= 1'b0;
            irq_q      <= 1'b0;
            cause_q    <= 4'd0;
            epc_q      <= '0;
            tval_q     <= '0;
            mst_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 12'd0;
            wr_data_q  <= '0;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
            priv_q     <= RESET_PRIV;
            busy_q     <= 1'b0;
        end else if (i_clk_en) begin
            state_q    <= state_d;
            mret_q     <= mret_d;
            irq_q      <= irq_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            tval_q     <= tval_d;
            mst_q      <= mst_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            redir_q    <= redir_d;
            redir_pc_q <= redir_pc_d;
            priv_q     <= priv_d;
            busy_q     <= busy_d;
        end
    end

    assign o_csr_wr_en   = wr_en_q;
    assign o_csr_wr_addr = wr_addr_q;
    assign o_csr_wr_data = wr_data_q;
    assign o_redirect    = redir_q;
    assign o_redirect_pc = redir_pc_q;
    assign o_priv        = priv_q;
    assign o_busy        = busy_q;
    assign o_stall       = busy_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: a transaction-level timeline model plus literal checks
// of CSR write order, data and redirect latency.
`timescale 1ns/1ps
module tb_trap_sequencer;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clk_en;
    logic         fd_v, em_v, mret;
    logic [3:0]   fd_code, em_code;
    logic [W-1:0] fd_pc, em_pc, em_addr, mepc, mtvec, mstatus;
`ifdef TRAP_SEQ_IRQ_EN
    logic         mtip, meip;
    logic [W-1:0] irq_pc, mie;
`endif
    logic         wr_en, flush_fd, flush_em, stall, redirect, busy;
    logic [11:0]  wr_addr;
    logic [W-1:0] wr_data, redirect_pc;
    logic [1:0]   priv;

    always #5 clk = ~clk;

    trap_sequencer dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_clk_en       (clk_en),
        .i_exc_valid_fd (fd_v),
        .i_exc_code_fd  (fd_code),
        .i_exc_pc_fd    (fd_pc),
        .i_exc_valid_em (em_v),
        .i_exc_code_em  (em_code),
        .i_exc_pc_em    (em_pc),
        .i_exc_addr_em  (em_addr),
        .i_mret_e       (mret),
        .i_mepc         (mepc),
        .i_mtvec        (mtvec),
        .i_mstatus      (mstatus),
`ifdef TRAP_SEQ_IRQ_EN
        .i_mtip         (mtip),
        .i_meip         (meip),
        .i_irq_pc       (irq_pc),
        .i_mie          (mie),
`endif
        .o_csr_wr_en    (wr_en),
        .o_csr_wr_addr  (wr_addr),
        .o_csr_wr_data  (wr_data),
        .o_flush_fd     (flush_fd),
        .o_flush_em     (flush_em),
        .o_stall        (stall),
        .o_redirect     (redirect),
        .o_redirect_pc  (redirect_pc),
        .o_priv         (priv),
        .o_busy         (busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic chk_on = 1'b0;
    logic exp_flush;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs for one cycle; the model holds a timeline of these per accepted request
    typedef struct packed {
        logic         wr;
        logic [11:0]  addr;
        logic [W-1:0] data;
        logic         redir;
        logic [W-1:0] pc;
        logic [1:0]   priv;
        logic         busy;
    } exp_t;

    exp_t cur;
    exp_t q[$];

    function automatic exp_t idle_e(input logic [1:0] p);
        exp_t e;
        e = '0;
        e.priv = p;
        return e;
    endfunction

    function automatic exp_t wr_e(input logic [11:0] a, input logic [W-1:0] d, input logic [1:0] p);
        exp_t e;
        e = '0;
        e.wr = 1'b1; e.addr = a; e.data = d; e.priv = p; e.busy = 1'b1;
        return e;
    endfunction

    function automatic exp_t rd_e(input logic [W-1:0] pc, input logic [1:0] p);
        exp_t e;
        e = '0;
        e.redir = 1'b1; e.pc = pc; e.priv = p; e.busy = 1'b1;
        return e;
    endfunction

    function automatic logic irq_pend();
`ifdef TRAP_SEQ_IRQ_EN
        return ((meip & mie[11]) | (mtip & mie[7])) & (mstatus[3] | (cur.priv != 2'b11));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic any_req();
        return em_v | mret | fd_v | irq_pend();
    endfunction

    task automatic model_accept();
        logic [1:0]   p;
        logic [W-1:0] ms, st, pc, epc, tval;
        logic         irq;
        logic [3:0]   code;
        p = cur.priv; ms = mstatus; irq = 1'b0; tval = '0; code = 4'd0; epc = '0;
        if (em_v) begin
            code = em_code; epc = em_pc;
            if (em_code >= 4 && em_code <= 7) tval = em_addr;
        end else if (mret) begin
            st = ms; st[3] = ms[7]; st[7] = 1'b1; st[12:11] = 2'b00;
            q.push_back(wr_e(12'h300, st, p));
            q.push_back(rd_e(mepc, ms[12:11]));
            return;
        end else if (fd_v) begin
            code = fd_code; epc = fd_pc;
            if (fd_code == 0 || fd_code == 1 || fd_code == 3) tval = fd_pc;
        end else begin
            irq = 1'b1;
`ifdef TRAP_SEQ_IRQ_EN
            code = (meip & mie[11]) ? 4'd11 : 4'd7;
            epc  = irq_pc;
`endif
        end
        st = ms; st[7] = ms[3]; st[3] = 1'b0; st[12:11] = p;
        pc = {mtvec[W-1:2], 2'b00};
`ifdef TRAP_SEQ_IRQ_EN
        if (irq && mtvec[1:0] == 2'b01) pc = pc + W'(4 * code);
`endif
        q.push_back(wr_e(12'h341, epc, p));
        q.push_back(wr_e(12'h342, {irq, {(W-5){1'b0}}, code}, p));
        q.push_back(wr_e(12'h343, tval, p));
        q.push_back(wr_e(12'h300, st, p));
        q.push_back(rd_e(pc, 2'b11));
    endtask

    // Model advances one timeline slot per enabled clock; a frozen clock holds the slot
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            cur = idle_e(2'b11);
        end else if (clk_en) begin
            if (!cur.busy && any_req()) model_accept();
            if (q.size() > 0) cur = q.pop_front();
            else cur = idle_e(cur.priv);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic [11:0]  wa[$];
    logic [W-1:0] wd[$];
    logic [W-1:0] rp[$];
    int           rc[$];
    int           ac[$];

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            exp_flush = !cur.busy && any_req() && clk_en;
            chk("csr_wr_en",   W'(wr_en),    W'(cur.wr));
            chk("csr_wr_addr", W'(wr_addr),  W'(cur.addr));
            chk("csr_wr_data", wr_data,      cur.data);
            chk("redirect",    W'(redirect), W'(cur.redir));
            chk("redirect_pc", redirect_pc,  cur.pc);
            chk("priv",        W'(priv),     W'(cur.priv));
            chk("busy",        W'(busy),     W'(cur.busy));
            chk("stall",       W'(stall),    W'(cur.busy));
            chk("flush_fd",    W'(flush_fd), W'(exp_flush));
            chk("flush_em",    W'(flush_em), W'(exp_flush));
            if (clk_en) begin
                if (wr_en)    begin wa.push_back(wr_addr); wd.push_back(wr_data); end
                if (redirect) begin rp.push_back(redirect_pc); rc.push_back(cyc); end
                if (flush_fd) ac.push_back(cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_req();
        fd_v = 1'b0; em_v = 1'b0; mret = 1'b0;
`ifdef TRAP_SEQ_IRQ_EN
        mtip = 1'b0; meip = 1'b0;
`endif
    endtask

    task automatic clear_logs();
        wa.delete(); wd.delete(); rp.delete(); rc.delete(); ac.delete();
    endtask

    task automatic chk_wr(input string name, input int i, input logic [11:0] a, input logic [W-1:0] d);
        if (i < wa.size()) begin
            chk({name, "_addr"}, W'(wa[i]), W'(a));
            chk({name, "_data"}, wd[i], d);
        end else begin
            chk({name, "_count"}, W'(wa.size()), W'(i + 1));
        end
    endtask

    task automatic chk_redir(input string name, input int i, input logic [W-1:0] pc, input int lat);
        if (i < rc.size() && ac.size() > 0) begin
            chk({name, "_pc"},  rp[i], pc);
            chk({name, "_lat"}, W'(rc[i] - ac[0]), W'(lat));
        end else begin
            chk({name, "_count"}, W'(rc.size()), W'(i + 1));
        end
    endtask

    initial begin
        clk_en = 1'b1; clear_req();
        fd_code = 4'd0; em_code = 4'd0; fd_pc = '0; em_pc = '0; em_addr = '0;
        mepc = '0; mtvec = 64'h400; mstatus = 64'h8;
`ifdef TRAP_SEQ_IRQ_EN
        irq_pc = '0; mie = '0;
`endif
        cur = idle_e(2'b11);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_priv", W'(priv), 64'd3);
        chk("rst_wr_en", W'(wr_en), 64'd0);
        chk("rst_busy", W'(busy), 64'd0);
        chk("rst_redirect", W'(redirect), 64'd0);
        rst = 1'b0; chk_on = 1'b1;
        step(2);

        // E/M load fault, MIE=1, priv M
        clear_logs();
        em_v = 1'b1; em_code = 4'd5; em_pc = 64'h80; em_addr = 64'h1003;
        step(1); clear_req(); step(7);
        chk("t1_nwr", W'(wa.size()), 64'd4);
        chk_wr("t1_epc", 0, 12'h341, 64'h80);
        chk_wr("t1_cause", 1, 12'h342, 64'd5);
        chk_wr("t1_tval", 2, 12'h343, 64'h1003);
        chk_wr("t1_stat", 3, 12'h300, 64'h1880);
        chk_redir("t1_redir", 0, 64'h400, 5);

        // F/D and E/M together; MRET raised while busy must be ignored
        clear_logs();
        fd_v = 1'b1; fd_code = 4'd2; fd_pc = 64'h500;
        em_v = 1'b1; em_code = 4'd7; em_pc = 64'h90; em_addr = 64'h2000;
        step(1); clear_req(); mret = 1'b1; step(2); mret = 1'b0; step(5);
        chk("t2_nacc", W'(ac.size()), 64'd1);
        chk("t2_nwr", W'(wa.size()), 64'd4);
        chk_wr("t2_cause", 1, 12'h342, 64'd7);
        chk_wr("t2_tval", 2, 12'h343, 64'h2000);
        chk("t2_nredir", W'(rc.size()), 64'd1);

        // MRET to U-mode
        clear_logs();
        mstatus = 64'h80; mepc = 64'h200; mret = 1'b1;
        step(1); clear_req(); step(4);
        chk_wr("t3_stat", 0, 12'h300, 64'h88);
        chk_redir("t3_redir", 0, 64'h200, 2);
        chk("t3_priv", W'(priv), 64'd0);

        // F/D fetch fault from U held across the sequence re-raises right after REDIR
        clear_logs();
        mstatus = 64'h8; fd_v = 1'b1; fd_code = 4'd1; fd_pc = 64'h600;
        step(7); clear_req(); step(7);
        chk_wr("t3b_tval", 2, 12'h343, 64'h600);
        chk_wr("t3b_stat", 3, 12'h300, 64'h80);
        chk("t3b_nacc", W'(ac.size()), 64'd2);
        if (ac.size() == 2) chk("t3b_reraise", W'(ac[1] - ac[0]), 64'd6);
        chk("t3b_priv", W'(priv), 64'd3);

        // E/M code outside 4..7 reports mtval 0
        clear_logs();
        em_v = 1'b1; em_code = 4'd8; em_pc = 64'h700; em_addr = 64'h999;
        step(1); clear_req(); step(7);
        chk_wr("t3c_tval", 2, 12'h343, 64'h0);

        // clock enable low for 3 cycles during W_CAUSE
        clear_logs();
        em_v = 1'b1; em_code = 4'd4; em_pc = 64'hA0; em_addr = 64'hB0;
        step(1); clear_req(); step(1);
        clk_en = 1'b0; step(3); clk_en = 1'b1; step(6);
        chk("t4_nwr", W'(wa.size()), 64'd4);
        chk_wr("t4_cause", 1, 12'h342, 64'd4);
        chk_redir("t4_redir", 0, 64'h400, 8);

        // reset during W_TVAL from U-mode
        mstatus = 64'h80; mret = 1'b1;
        step(1); clear_req(); step(3);
        mstatus = 64'h8;
        em_v = 1'b1; em_code = 4'd6; em_pc = 64'hC0; em_addr = 64'hD0;
        step(1); clear_req(); step(2);
        chk("t5_pre_priv", W'(priv), 64'd0);
        #2 rst = 1'b1; #1;
        chk("t5_wr_en", W'(wr_en), 64'd0);
        chk("t5_wr_data", wr_data, 64'd0);
        chk("t5_wr_addr", W'(wr_addr), 64'd0);
        chk("t5_priv", W'(priv), 64'd3);
        chk("t5_busy", W'(busy), 64'd0);
        chk("t5_stall", W'(stall), 64'd0);
        step(1); rst = 1'b0; clear_logs(); step(8);
        chk("t5_nredir", W'(rc.size()), 64'd0);
        chk("t5_nwr", W'(wa.size()), 64'd0);

`ifdef TRAP_SEQ_IRQ_EN
        // vectored machine timer interrupt
        clear_logs();
        mstatus = 64'h8; mie = 64'h80; mtvec = 64'h101; irq_pc = 64'h1234; mtip = 1'b1;
        step(1); clear_req(); step(7);
        chk_wr("t6_epc", 0, 12'h341, 64'h1234);
        chk_wr("t6_cause", 1, 12'h342, 64'h8000000000000007);
        chk_wr("t6_tval", 2, 12'h343, 64'h0);
        chk_redir("t6_redir", 0, 64'h11C, 5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
